regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_clr_fsm.sv | 68 ++++++
 rtl/regfile_mp.sv | 99 +++++++++
 tb/tb_regfile_mp.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types, default parameters and address-width helper for the multi-port register file.
package regfile_pkg;

    localparam int unsigned DEF_XLEN    = 32;
    localparam int unsigned DEF_NREGS   = 32;
    localparam int unsigned DEF_NRP     = 2;
    localparam int unsigned DEF_ZERO_R0 = 1;
    localparam int unsigned DEF_BYPASS  = 1;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_t;

    // Address width for n registers, never narrower than one bit.
    function automatic int unsigned calc_aw(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// Sequences a full zeroing pass over the register file after reset or on request.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = DEF_NREGS,
    parameter int unsigned AW    = calc_aw(DEF_NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          ready,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    clr_state_t    state;
    clr_state_t    state_next;
    logic [AW-1:0] clr_cnt;
    logic [AW-1:0] cnt_next;
    logic          ready_next;
    logic          clr_we_next;

    // State, counter and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            ready   <= 1'b0;
            clr_we  <= 1'b1;
        end else begin
            state   <= state_next;
            clr_cnt <= cnt_next;
            ready   <= ready_next;
            clr_we  <= clr_we_next;
        end
    end

    // Next state: walk every register once, then idle until a clear request.
    always_comb begin
        state_next  = state;
        cnt_next    = clr_cnt;
        case (state)
            CLEAR: begin
                if (clr_cnt == AW'(NREGS - 1)) begin
                    state_next = READY;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = clr_cnt + AW'(1);
                end
            end
            READY: begin
                if (clr_req) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = CLEAR;
                cnt_next   = '0;
            end
        endcase
        ready_next  = (state_next == READY);
        clr_we_next = (state_next == CLEAR);
    end

    assign clr_addr = clr_cnt;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with optional hard-wired zero register and write bypass.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN    = DEF_XLEN,
    parameter int unsigned NREGS   = DEF_NREGS,
    parameter int unsigned NRP     = DEF_NRP,
    parameter int unsigned ZERO_R0 = DEF_ZERO_R0,
    parameter int unsigned BYPASS  = DEF_BYPASS,
    localparam int unsigned AW     = calc_aw(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_en,
    input  logic [NRP*AW-1:0]   rd_addr,
    output logic [NRP*XLEN-1:0] rd_data,
    input  logic                we,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                clr_req,
    output logic                ready,
    output logic                wr_drop
);

    logic [XLEN-1:0] mem [NREGS];
    logic            clr_we;
    logic [AW-1:0]   clr_addr;
    logic            wr_commit;

    regfile_clr_fsm #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clr_fsm (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A write lands only in READY, outside a clear request, in range and not on a hard zero.
    always_comb begin
        wr_commit = we && ready && !clr_req && (32'(wr_addr) < NREGS);
        if (ZERO_R0 != 0 && wr_addr == '0) begin
            wr_commit = 1'b0;
        end
    end

    // Storage: clear pass has priority; contents are not reset.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_commit) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Flag any requested write that was not committed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= we && !wr_commit;
        end
    end

    for (genvar i = 0; i < NRP; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data_c;
        logic [XLEN-1:0] q;

        assign addr = rd_addr[i*AW +: AW];

        // Port read mux: zero for invalid/hard-zero addresses, else bypass or stored value.
        always_comb begin
            data_c = mem[addr];
            if (32'(addr) >= NREGS || (ZERO_R0 != 0 && addr == '0)) begin
                data_c = '0;
            end else if (BYPASS != 0 && wr_commit && wr_addr == addr) begin
                data_c = wr_data;
            end
        end

        // Registered read data; forced to zero while clearing.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                q <= '0;
            end else if (!ready) begin
                q <= '0;
            end else if (rd_en) begin
                q <= data_c;
            end
        end

        assign rd_data[i*XLEN +: XLEN] = q;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: default file, a no-bypass copy, and a 24-entry copy.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Shared stimulus for the 32-entry bypass (a) and no-bypass (b) instances
    logic        rd_en, we, clr_req;
    logic [9:0]  rd_addr;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [63:0] rd_data_a, rd_data_b;
    logic        ready_a, ready_b, drop_a, drop_b;

    // Separate stimulus for the 24-entry instance (c)
    logic        rd_en_c, we_c;
    logic [9:0]  rd_addr_c;
    logic [4:0]  wr_addr_c;
    logic [31:0] wr_data_c;
    logic [63:0] rd_data_c;
    logic        ready_c, drop_c;

    regfile_mp #(.XLEN(32), .NREGS(32), .NRP(2), .ZERO_R0(1), .BYPASS(1)) u_a (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req),
        .ready(ready_a), .wr_drop(drop_a));

    regfile_mp #(.XLEN(32), .NREGS(32), .NRP(2), .ZERO_R0(1), .BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req),
        .ready(ready_b), .wr_drop(drop_b));

    regfile_mp #(.XLEN(32), .NREGS(24), .NRP(2), .ZERO_R0(1), .BYPASS(1)) u_c (
        .clk(clk), .rst(rst), .rd_en(rd_en_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c),
        .we(we_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c), .clr_req(1'b0),
        .ready(ready_c), .wr_drop(drop_c));

    typedef struct {
        string       name;
        logic [63:0] exp_a;
        logic [63:0] exp_b;
    } ab_exp_t;

    typedef struct {
        string       name;
        logic [63:0] exp;
    } c_exp_t;

    ab_exp_t q_ab[$];
    c_exp_t  q_c[$];
    ab_exp_t e_ab;
    c_exp_t  e_c;

    int checks = 0;
    int errors = 0;

    logic mon_ab = 1'b0;
    logic mon_c  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // A read is presented on the edge after it was accepted
    always @(posedge clk) begin
        mon_ab <= rd_en && ready_a;
        mon_c  <= rd_en_c && ready_c;
    end

    // Monitor: pop expected data whenever a DUT presents a fresh read
    always @(negedge clk) begin
        if (mon_ab) begin
            if (q_ab.size() == 0) begin
                chk("unexpected_read_ab", rd_data_a, 64'hx);
            end else begin
                e_ab = q_ab.pop_front();
                chk({e_ab.name, "_a"}, rd_data_a, e_ab.exp_a);
                chk({e_ab.name, "_b"}, rd_data_b, e_ab.exp_b);
            end
        end
        if (mon_c) begin
            if (q_c.size() == 0) begin
                chk("unexpected_read_c", rd_data_c, 64'hx);
            end else begin
                e_c = q_c.pop_front();
                chk(e_c.name, rd_data_c, e_c.exp);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic read2(input logic [4:0] a0, input logic [4:0] a1, input string name,
                         input logic [63:0] ea, input logic [63:0] eb);
        ab_exp_t e;
        e.name  = name;
        e.exp_a = ea;
        e.exp_b = eb;
        q_ab.push_back(e);
        rd_en   = 1'b1;
        rd_addr = {a1, a0};
        cyc();
        rd_en   = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic exp_drop,
                      input string name);
        we      = 1'b1;
        wr_addr = a;
        wr_data = d;
        cyc();
        we      = 1'b0;
        chk(name, 64'(drop_a), 64'(exp_drop));
    endtask

    task automatic read_c(input logic [4:0] a0, input logic [4:0] a1, input string name,
                          input logic [63:0] ex);
        c_exp_t e;
        e.name = name;
        e.exp  = ex;
        q_c.push_back(e);
        rd_en_c   = 1'b1;
        rd_addr_c = {a1, a0};
        cyc();
        rd_en_c   = 1'b0;
    endtask

    task automatic wr_c(input logic [4:0] a, input logic [31:0] d, input logic exp_drop,
                        input string name);
        we_c      = 1'b1;
        wr_addr_c = a;
        wr_data_c = d;
        cyc();
        we_c      = 1'b0;
        chk(name, 64'(drop_c), 64'(exp_drop));
    endtask

    initial begin
        int na, nb, nc;
        rst = 1'b1;
        rd_en = 1'b0; we = 1'b0; clr_req = 1'b0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        rd_en_c = 1'b0; we_c = 1'b0; rd_addr_c = '0; wr_addr_c = '0; wr_data_c = '0;
        cyc();
        cyc();
        chk("reset_ready", 64'(ready_a), 64'h0);
        chk("reset_rd_data", rd_data_a, 64'h0);
        chk("reset_wr_drop", 64'(drop_a), 64'h0);

        // Initial clear pass length
        rst = 1'b0;
        na = 0; nb = 0; nc = 0;
        for (int n = 1; n <= 40; n++) begin
            cyc();
            if (ready_a && na == 0) na = n;
            if (ready_b && nb == 0) nb = n;
            if (ready_c && nc == 0) nc = n;
        end
        chk("init_ready_rise_a", 64'(na), 64'd32);
        chk("init_ready_rise_b", 64'(nb), 64'd32);
        chk("init_ready_rise_c", 64'(nc), 64'd24);

        for (int r = 0; r < 32; r += 2) begin
            read2(5'(r), 5'(r + 1), "zero_read", 64'h0, 64'h0);
        end

        // Basic write/read and hard-zero r0
        wr(5'd5, 32'hDEADBEEF, 1'b0, "wr_r5_drop");
        read2(5'd5, 5'd0, "r5_r0", {32'h0, 32'hDEADBEEF}, {32'h0, 32'hDEADBEEF});
        wr(5'd0, 32'h1, 1'b1, "wr_r0_drop");
        read2(5'd0, 5'd0, "r0_after_wr", 64'h0, 64'h0);

        // Same-cycle write and read of r7
        wr(5'd7, 32'hA, 1'b0, "wr_r7_drop");
        we = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
        read2(5'd7, 5'd7, "r7_bypass", {2{32'h12345678}}, {2{32'h0000000A}});
        we = 1'b0;
        read2(5'd7, 5'd7, "r7_after", {2{32'h12345678}}, {2{32'h12345678}});
        cyc();
        chk("rd_hold", rd_data_a, {2{32'h12345678}});

        // Clear request colliding with a write
        wr(5'd3, 32'h33, 1'b0, "wr_r3_drop");
        read2(5'd3, 5'd5, "r3_before_clr", {32'hDEADBEEF, 32'h33}, {32'hDEADBEEF, 32'h33});
        clr_req = 1'b1; we = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
        cyc();
        clr_req = 1'b0; we = 1'b0;
        chk("clr_wr_drop", 64'(drop_a), 64'h1);
        chk("clr_ready_low", 64'(ready_a), 64'h0);
        na = 0;
        for (int n = 1; n <= 40; n++) begin
            if (n == 3) rd_en = 1'b1;
            if (n == 5) begin
                clr_req = 1'b1; we = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
            end
            cyc();
            if (n == 3) begin
                rd_en = 1'b0;
                chk("clear_rd_zero", rd_data_a, 64'h0);
            end
            if (n == 5) begin
                clr_req = 1'b0; we = 1'b0;
                chk("clear_wr_drop", 64'(drop_a), 64'h1);
            end
            if (ready_a && na == 0) na = n;
        end
        chk("clr_ready_rise", 64'(na), 64'd32);
        read2(5'd3, 5'd9, "r3_r9_after_clr", 64'h0, 64'h0);
        read2(5'd5, 5'd7, "r5_r7_after_clr", 64'h0, 64'h0);

        // Reset ten cycles into a clear pass restarts it
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        for (int n = 0; n < 10; n++) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        na = 0; nb = 0;
        for (int n = 1; n <= 40; n++) begin
            cyc();
            if (ready_a && na == 0) na = n;
            if (ready_b && nb == 0) nb = n;
        end
        chk("rst_mid_clr_rise_a", 64'(na), 64'd32);
        chk("rst_mid_clr_rise_b", 64'(nb), 64'd32);

        // 24-entry instance: out-of-range address
        wr_c(5'd30, 32'hBAD, 1'b1, "c_wr30_drop");
        wr_c(5'd20, 32'h2020, 1'b0, "c_wr20_drop");
        wr_c(5'd23, 32'h2323, 1'b0, "c_wr23_drop");
        read_c(5'd30, 5'd20, "c_r30_r20", {32'h2020, 32'h0});
        read_c(5'd23, 5'd23, "c_r23", {2{32'h2323}});

        cyc();
        cyc();
        chk("q_ab_drained", 64'(q_ab.size()), 64'd0);
        chk("q_c_drained", 64'(q_c.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
